// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the RAM burst master.
//   state_t / IDLE, WRITE, READ, DRAIN : controller state encoding
//   fifo_occupancy()                   : read-path slots committed after this cycle's pop
package ram_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t WRITE = 2'd1;
    localparam state_t READ  = 2'd2;
    localparam state_t DRAIN = 2'd3;

    // Entries already buffered plus the read still travelling from the RAM,
    // minus the entry the consumer takes this cycle. A new read may only be
    // issued while this stays below the FIFO depth of two.
    function automatic logic [2:0] fifo_occupancy(input logic [1:0] count,
                                                  input logic       inflight,
                                                  input logic       pop);
        return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/ram_rd_fifo.sv
// ram_rd_fifo: two-entry first-word-fall-through FIFO for returned read data.
//   clk, rst   : clock, asynchronous active-high reset (clears storage)
//   push       : write push_data this cycle (ignored when full)
//   push_data  : data word to store
//   pop        : consume the head entry (ignored when empty)
//   count      : number of valid entries, 0..2
//   head       : oldest entry, held stable until popped
module ram_rd_fifo
    import ram_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_r [0:1];
    logic             rd_ptr_r;
    logic             wr_ptr_r;
    logic [1:0]       count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Guard push/pop against full/empty so the pointers can never slip.
    always_comb begin
        push_ok_s = push && (count_r != 2'd2);
        pop_ok_s  = pop  && (count_r != 2'd0);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r[0] <= {WIDTH{1'b0}};
            mem_r[1] <= {WIDTH{1'b0}};
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/ram_burst_master.sv
// ram_burst_master: turns single burst commands into per-beat accesses on a
// single-port RAM with one cycle of read latency.
//   clk, rst                        : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready             : command handshake (accepted only when idle)
//   cmd_write, cmd_addr, cmd_len    : direction, start address, beats minus one
//   wr_valid/wr_ready/wr_data       : write-beat stream into the RAM
//   rd_valid/rd_ready/rd_data       : read-beat stream out of the RAM
//   busy                            : a burst is in progress
//   ram_enable, ram_wr_en,
//   ram_address, ram_data_in        : RAM request port
//   ram_data_out                    : RAM read data, valid one cycle after a read
module ram_burst_master
    import ram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [DEPTH-1:0] cmd_addr,
    input  logic [DEPTH-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             ram_enable,
    output logic             ram_wr_en,
    output logic [DEPTH-1:0] ram_address,
    output logic [WIDTH-1:0] ram_data_in,
    input  logic [WIDTH-1:0] ram_data_out
);

    localparam logic [DEPTH-1:0] ADDR_ONE  = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [DEPTH:0]   COUNT_ONE = {{DEPTH{1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [DEPTH-1:0] addr_r;
    logic [DEPTH-1:0] addr_nxt_s;
    logic [DEPTH:0]   count_r;      // beats still to issue; one wider to hold 2**DEPTH
    logic [DEPTH:0]   count_nxt_s;
    logic             inflight_r;   // a read was issued last cycle; its data arrives now

    logic [1:0]       fifo_count_s;
    logic [WIDTH-1:0] fifo_head_s;
    logic             pop_s;
    logic             issue_s;
    logic             write_beat_s;
    logic             last_beat_s;

    // Beat qualification. The issue rule counts the entry being popped this
    // cycle as free, which is what lets rd_ready held high stream one beat per
    // cycle through a FIFO of only two entries.
    always_comb begin
        pop_s        = (fifo_count_s != 2'd0) && rd_ready;
        write_beat_s = (state_r == WRITE) && wr_valid;
        last_beat_s  = (count_r == COUNT_ONE);
        if (state_r == READ) begin
            issue_s = fifo_occupancy(fifo_count_s, inflight_r, pop_s) < 3'd2;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state, address and beat-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        count_nxt_s = count_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    addr_nxt_s  = cmd_addr;
                    count_nxt_s = {1'b0, cmd_len} + COUNT_ONE;
                    if (cmd_write) begin
                        state_nxt_s = WRITE;
                    end else begin
                        state_nxt_s = READ;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITE: begin
                if (write_beat_s) begin
                    addr_nxt_s  = addr_r + ADDR_ONE;
                    count_nxt_s = count_r - COUNT_ONE;
                    if (last_beat_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = WRITE;
                    end
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            READ: begin
                if (issue_s) begin
                    addr_nxt_s  = addr_r + ADDR_ONE;
                    count_nxt_s = count_r - COUNT_ONE;
                    if (last_beat_s) begin
                        state_nxt_s = DRAIN;
                    end else begin
                        state_nxt_s = READ;
                    end
                end else begin
                    state_nxt_s = READ;
                end
            end
            DRAIN: begin
                if ((fifo_count_s == 2'd0) && !inflight_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                addr_nxt_s  = {DEPTH{1'b0}};
                count_nxt_s = {(DEPTH+1){1'b0}};
            end
        endcase
    end

    // Controller state registers; reset drops any read still returning.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            addr_r     <= {DEPTH{1'b0}};
            count_r    <= {(DEPTH+1){1'b0}};
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            addr_r     <= addr_nxt_s;
            count_r    <= count_nxt_s;
            inflight_r <= issue_s;
        end
    end

    // Read data lands in the FIFO the cycle after its issue.
    ram_rd_fifo #(
        .WIDTH (WIDTH)
    ) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_r),
        .push_data (ram_data_out),
        .pop       (pop_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s)
    );

    // Handshake, status and RAM port outputs. Write data is gated so the RAM
    // only ever sees wr_data on an accepted write beat.
    always_comb begin
        cmd_ready   = (state_r == IDLE);
        busy        = (state_r != IDLE);
        wr_ready    = (state_r == WRITE);
        rd_valid    = (fifo_count_s != 2'd0);
        rd_data     = fifo_head_s;
        ram_enable  = write_beat_s || issue_s;
        ram_wr_en   = write_beat_s;
        ram_address = addr_r;
        if (write_beat_s) begin
            ram_data_in = wr_data;
        end else begin
            ram_data_in = {WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_ram_burst_master.sv
module tb_ram_burst_master;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [DEPTH-1:0] cmd_addr;
    logic [DEPTH-1:0] cmd_len;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             ram_enable;
    logic             ram_wr_en;
    logic [DEPTH-1:0] ram_address;
    logic [WIDTH-1:0] ram_data_in;
    logic [WIDTH-1:0] ram_data_out;

    int num_checks = 0;
    int num_errors = 0;
    int en_cnt     = 0;

    logic [WIDTH-1:0] ram_mem [0:15];
    logic [WIDTH-1:0] ref_mem [0:15];
    logic [11:0]      wr_exp [$];
    logic [7:0]       rd_exp [$];

    logic             prev_stall;
    logic [WIDTH-1:0] prev_data;

    ram_burst_master #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .busy         (busy),
        .ram_enable   (ram_enable),
        .ram_wr_en    (ram_wr_en),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_wr_en) ram_mem[ram_address] <= ram_data_in;
            else           ram_data_out <= ram_mem[ram_address];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Monitor: scoreboard pops, stall stability, gating of the RAM enable.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (ram_enable) en_cnt++;
            if (ram_enable && ram_wr_en) begin
                if (wr_exp.size() == 0) check_eq("wr_unexpected", 32'(wr_exp.size()), 32'd1);
                else check_eq("wr_beat", 32'({ram_address, ram_data_in}), 32'(wr_exp.pop_front()));
            end
            if (wr_ready) check_eq("wr_en_gate", 32'(ram_enable), 32'(wr_valid));
            if (!busy) check_eq("idle_no_en", 32'(ram_enable), 32'd0);
            check_eq("fifo_le2", 32'(dut.u_rd_fifo.count <= 2'd2), 32'd1);
            if (prev_stall) begin
                check_eq("rd_hold_valid", 32'(rd_valid), 32'd1);
                check_eq("rd_hold_data", 32'(rd_data), 32'(prev_data));
            end
            if (rd_valid && rd_ready) begin
                if (rd_exp.size() == 0) check_eq("rd_unexpected", 32'(rd_exp.size()), 32'd1);
                else check_eq("rd_beat", 32'(rd_data), 32'(rd_exp.pop_front()));
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
        end
    end

    task automatic do_cmd(input logic wr, input logic [3:0] addr, input logic [3:0] len);
        int t = 0;
        while (!cmd_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 4'($urandom);
        cmd_len   = 4'($urandom);
    endtask

    task automatic write_burst(input logic [3:0] addr, input logic [3:0] len, input logic [7:0] base,
                               input logic [7:0] pat, input int plen);
        int n = 0;
        int ones = 0;
        int beat = 0;
        int cyc = 0;
        logic [3:0] a;
        while (ones < int'(len) + 1) begin
            if (pat[n % plen]) ones++;
            n++;
        end
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 4'(i);
            wr_exp.push_back({a, base + 8'(i)});
            ref_mem[a] = base + 8'(i);
        end
        en_cnt = 0;
        do_cmd(1'b1, addr, len);
        while (beat <= int'(len) && cyc < 100) begin
            wr_valid = pat[cyc % plen];
            wr_data  = base + 8'(beat);
            @(negedge clk);
            if (wr_valid && wr_ready) beat++;
            cyc++;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        wr_data  = 8'($urandom);
        check_eq("wr_cycles", 32'(cyc), 32'(n));
        check_eq("wr_accesses", 32'(en_cnt), 32'(len) + 32'd1);
        check_eq("wr_idle_after", 32'(busy), 32'd0);
        check_eq("wr_queue_empty", 32'(wr_exp.size()), 32'd0);
    endtask

    task automatic read_burst(input logic [3:0] addr, input logic [3:0] len, input logic [7:0] pat,
                              input int plen, input logic streaming);
        int cyc = 0;
        int first_valid = -1;
        int first_pop = -1;
        int last_pop = -1;
        for (int i = 0; i <= int'(len); i++) rd_exp.push_back(ref_mem[addr + 4'(i)]);
        en_cnt = 0;
        do_cmd(1'b0, addr, len);
        while ((busy || cyc == 0) && cyc < 300) begin
            rd_ready = pat[cyc % plen];
            @(negedge clk);
            if (rd_valid && first_valid < 0) first_valid = cyc;
            if (rd_valid && rd_ready) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            cyc++;
            @(posedge clk); #1;
        end
        rd_ready = 1'b0;
        check_eq("rd_done", 32'(busy), 32'd0);
        check_eq("rd_latency", 32'(first_valid), 32'd2);
        check_eq("rd_all_returned", 32'(rd_exp.size()), 32'd0);
        check_eq("rd_accesses", 32'(en_cnt), 32'(len) + 32'd1);
        check_eq("rd_valid_after", 32'(rd_valid), 32'd0);
        if (streaming) check_eq("rd_stream", 32'(last_pop - first_pop), 32'(len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = 8'h30 + 8'(i);
            ref_mem[i] = 8'h30 + 8'(i);
        end
        ram_data_out = 8'h00;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 4'h7;
        cmd_len   = 4'h5;
        wr_valid  = 1'b0;
        wr_data   = 8'h5A;
        rd_ready  = 1'b0;
        #12;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_ram_enable", 32'(ram_enable), 32'd0);
        check_eq("rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
        check_eq("rst_ram_address", 32'(ram_address), 32'd0);
        check_eq("rst_ram_data_in", 32'(ram_data_in), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic write then streaming read.
        write_burst(4'h2, 4'd3, 8'hA0, 8'b0000_0001, 1);
        read_burst(4'h2, 4'd3, 8'b0000_0001, 1, 1'b1);

        // Address wrap-around.
        write_burst(4'hE, 4'd2, 8'h50, 8'b0000_0001, 1);
        check_eq("wrap_ram_E", 32'(ram_mem[14]), 32'h50);
        check_eq("wrap_ram_F", 32'(ram_mem[15]), 32'h51);
        check_eq("wrap_ram_0", 32'(ram_mem[0]), 32'h52);
        read_burst(4'hE, 4'd2, 8'b0000_0001, 1, 1'b1);

        // Full-depth read with back-pressure 1,0,0,1.
        read_burst(4'h0, 4'd15, 8'b0000_1001, 4, 1'b0);

        // Write with wr_valid gaps 1,0,1,0,1,1, then read it back.
        write_burst(4'h8, 4'd3, 8'hC0, 8'b0011_0101, 6);
        read_burst(4'h8, 4'd3, 8'b0000_0001, 1, 1'b1);

        // Reset in READ with a full FIFO.
        do_cmd(1'b0, 4'h0, 4'd15);
        rd_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check_eq("pre_rst_fifo_full", 32'(dut.u_rd_fifo.count), 32'd2);
        check_eq("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_ram_enable", 32'(ram_enable), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rd_exp.delete();
        @(posedge clk); #1;
        check_eq("post_rst_rd_valid", 32'(rd_valid), 32'd0);
        read_burst(4'h5, 4'd0, 8'b0000_0001, 1, 1'b1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
